// File: rtl/window_aligner_z_if.sv
// Stream bus for window_aligner_z: upstream beat in, delayed beat out, sequence-error status.
// Signal names follow the block's port list; the slave modport is the aligner's view.
interface window_aligner_z_if #(
  parameter int CHANNELS   = 1,
  parameter int DATA_WIDTH = 8
);
  logic [CHANNELS*DATA_WIDTH-1:0] data_i;
  logic [15:0]                    col_i;
  logic [15:0]                    row_i;
  logic                           valid_i;
  logic                           ready_o;
  logic [CHANNELS*DATA_WIDTH-1:0] data_o;
  logic [15:0]                    col_o;
  logic [15:0]                    row_o;
  logic                           valid_o;
  logic                           ready_i;
  logic                           seq_err_o;
  logic                           err_clr_i;

  modport master (
    output data_i, col_i, row_i, valid_i, ready_i, err_clr_i,
    input  ready_o, data_o, col_o, row_o, valid_o, seq_err_o
  );

  modport slave (
    input  data_i, col_i, row_i, valid_i, ready_i, err_clr_i,
    output ready_o, data_o, col_o, row_o, valid_o, seq_err_o
  );
endinterface

// File: rtl/window_aligner_z.sv
// Window-centre aligner: beat k leaves one cycle after accept k+DELAY (registered output, DELAY=0 bypasses the RAM).
// Backpressure: ready_o = !valid_o || ready_i, so a stalled output register holds off the source.
module window_aligner_z #(
  parameter int CHANNELS                    = 1,
  parameter int DATA_WIDTH                  = 8,
  parameter int IMAGE_WIDTH                 = 640,
  parameter int IMAGE_HEIGHT                = 480,
  parameter int WINDOW_WIDTH                = 3,
  parameter int WINDOW_HEIGHT               = 3,
  parameter int WINDOW_WIDTH_CENTER_OFFSET  = 0,
  parameter int WINDOW_HEIGHT_CENTER_OFFSET = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  window_aligner_z_if.slave bus
);

  localparam int WC         = (WINDOW_WIDTH - 1) / 2 + WINDOW_WIDTH_CENTER_OFFSET;
  localparam int HC         = (WINDOW_HEIGHT - 1) / 2 + WINDOW_HEIGHT_CENTER_OFFSET;
  localparam int WWR        = (WINDOW_WIDTH - 1) - WC;
  localparam int WHR        = (WINDOW_HEIGHT - 1) - HC;
  localparam int DELAY      = WHR * IMAGE_WIDTH + WWR;
  localparam int ADDR_WIDTH = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam int DW         = CHANNELS * DATA_WIDTH;

  localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [15:0]   col;
    logic [15:0]   row;
  } beat_t;

  // Reset asserts asynchronously but is released through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_s = rst_sync_q[1];

  beat_t in_beat, rd_beat, out_q, out_d;
  logic  vld_q, vld_d;
  logic  ready, accept, xfer, primed, load;

  assign in_beat = {bus.data_i, bus.col_i, bus.row_i};
  assign ready   = !vld_q || bus.ready_i;
  assign accept  = bus.valid_i && ready;
  assign xfer    = vld_q && bus.ready_i;
  assign load    = accept && primed;

  if (DELAY == 0) begin : g_bypass
    assign rd_beat = in_beat;
    assign primed  = 1'b1;
  end else begin : g_ram
    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DELAY_A = ADDR_WIDTH'(DELAY);

    beat_t                 mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, prime_q, prime_d, rd_addr;

    // Combinational read sees the pre-write contents of the slot being recycled.
    assign rd_addr = wptr_q - DELAY_A;
    assign rd_beat = mem_q[rd_addr];
    assign primed  = (prime_q == DELAY_A);

    always_comb begin
      wptr_d  = wptr_q;
      prime_d = prime_q;
      if (accept) begin
        wptr_d = wptr_q + ADDR_WIDTH'(1);
        if (!primed) prime_d = prime_q + ADDR_WIDTH'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
        wptr_q  <= '0;
        prime_q <= '0;
      end else begin
        wptr_q  <= wptr_d;
        prime_q <= prime_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (accept) mem_q[wptr_q] <= in_beat;
    end
  end

  logic        first_q, first_d, err_q, err_d, mismatch;
  logic [15:0] exp_col_q, exp_col_d, exp_row_q, exp_row_d;

  always_comb begin
    first_d   = first_q;
    exp_col_d = exp_col_q;
    exp_row_d = exp_row_q;
    mismatch  = accept && first_q &&
                ((bus.col_i != exp_col_q) || (bus.row_i != exp_row_q));
    if (accept) begin
      first_d = 1'b1;
      // Expectation always resyncs to the tags actually received.
      if (bus.col_i == COL_LAST) begin
        exp_col_d = '0;
        exp_row_d = (bus.row_i == ROW_LAST) ? '0 : bus.row_i + 16'd1;
      end else begin
        exp_col_d = bus.col_i + 16'd1;
        exp_row_d = bus.row_i;
      end
    end
    if (mismatch)           err_d = 1'b1;
    else if (bus.err_clr_i) err_d = 1'b0;
    else                    err_d = err_q;
  end

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    if (load) begin
      out_d = rd_beat;
      vld_d = 1'b1;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      out_q     <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      exp_col_q <= '0;
      exp_row_q <= '0;
      err_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      exp_col_q <= exp_col_d;
      exp_row_q <= exp_row_d;
      err_q     <= err_d;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.data_o    = out_q.dat;
  assign bus.col_o     = out_q.col;
  assign bus.row_o     = out_q.row;
  assign bus.valid_o   = vld_q;
  assign bus.seq_err_o = err_q;

endmodule
